// File: rtl/riscv_fetch_pkg.sv
// Shared types and widths for the instruction-fetch queue.
package riscv_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int XLEN    = 64;

  typedef struct packed {
    logic               valid;
    logic               filled;
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch stage: issues PCs to instruction memory and queues returned words in order for decode.
// Define FETCH_PERF_EN to add the perf_stall / perf_drop counters.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    addr,
  input  logic               mispred,
  output logic               ready,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [XLEN-1:0]    dec_pc,
  output logic [INSTR_W-1:0] dec_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]        perf_stall,
  output logic [63:0]        perf_drop
`endif
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CNT_MAX = (MAX_OUTSTANDING > DEPTH) ? MAX_OUTSTANDING : DEPTH;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW:0]   MAX_C   = (CW+1)'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t entries_q [DEPTH];
  fetch_entry_t entries_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0] count_q, count_d, drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] unfilled;
  logic [CW:0]   inflight;
  logic          pop;
  logic          resp_drop;
  logic          resp_fill;

  always_comb begin
    unfilled = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && !entries_q[i].filled) unfilled = unfilled + 1'b1;
    end
  end

  assign inflight       = {1'b0, drop_cnt_q} + {1'b0, unfilled};
  assign imem_req_valid = rst && !mispred && (count_q < DEPTH_C) && (inflight < MAX_C);
  assign imem_req_addr  = addr;
  assign ready          = imem_req_valid && imem_req_ready;

  assign dec_valid = entries_q[head_q].valid && entries_q[head_q].filled;
  assign dec_pc    = entries_q[head_q].pc;
  assign dec_instr = entries_q[head_q].instr;

  assign pop       = dec_valid && dec_ready;
  assign resp_drop = imem_resp_valid && (drop_cnt_q != '0);
  assign resp_fill = imem_resp_valid && (drop_cnt_q == '0);

  // A flush wins over everything else; responses already owed by memory become drops.
  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (mispred) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      drop_cnt_d = drop_cnt_q + unfilled - CW'(imem_resp_valid);
    end else begin
      if (resp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
      if (resp_fill) begin
        entries_d[fill_q].instr  = imem_resp_data;
        entries_d[fill_q].filled = 1'b1;
        fill_d = fill_q + 1'b1;
      end
      if (pop) begin
        entries_d[head_q].valid = 1'b0;
        head_d = head_q + 1'b1;
      end
      if (ready) begin
        entries_d[tail_q].valid  = 1'b1;
        entries_d[tail_q].filled = 1'b0;
        entries_d[tail_q].pc     = addr;
        entries_d[tail_q].instr  = '0;
        tail_d = tail_q + 1'b1;
      end
      count_d = count_q + CW'(ready) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [63:0] perf_stall_q, perf_drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (!ready && !mispred) perf_stall_q <= perf_stall_q + 64'd1;
      if (imem_resp_valid && ((drop_cnt_q != '0) || mispred)) perf_drop_q <= perf_drop_q + 64'd1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_drop  = perf_drop_q;
`endif

  // Memory must never return a word that no live or dropped request is waiting for.
  assert property (@(posedge clk) disable iff (!rst)
    (imem_resp_valid && (drop_cnt_q == '0)) |-> (unfilled != '0));

endmodule
